if_id_stage: RTL
================

# if_id_stage

IF/ID pipeline register with load-use hazard detection and branch flush for the 5-stage RV32I core. It sits between instruction fetch and the decode-stage control decoder: it registers the fetched instruction and PC, drives the instruction word into the decoder's `opcode` input, and generates `MuxControlEn`, which forces the decoder to a nop, plus the PC write enable. It also keeps saturating stall and flush counters for performance debug.

## Interface
- `NOP_INSTR`, default 32'h0000_0013 (`addi x0,x0,0`): word loaded into the register on reset, flush or fetch bubble.
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `pc_if`  in  32  PC of the instruction being fetched.
- `instr_if`  in  32  fetched instruction word.
- `fetch_valid`  in  1  `instr_if` is valid this cycle.
- `stall_ext`  in  1  global freeze from the data-memory side.
- `branch_taken`  in  1  EX resolved a taken branch or jump; the PC is redirected.
- `id_ex_mem_read`  in  1  MemRead of the instruction currently in EX.
- `id_ex_rd`  in  5  destination register of the instruction in EX.
- `pc_id`  out  32  registered PC for decode.
- `instr_id`  out  32  registered instruction; feeds the decoder `opcode`.
- `valid_id`  out  1  `instr_id` is a real instruction.
- `MuxControlEn`  out  1  forces the decoder to nop.
- `pc_write`  out  1  PC register enable.
- `stall_cnt`  out  `CNT_W`  saturating count of load-use stall cycles.
- `flush_cnt`  out  `CNT_W`  saturating count of flushes.

## Operation
Source-register usage is decoded locally from `instr_id[6:0]`. The decoder's HazardRs outputs are not used, which avoids a combinational loop through `MuxControlEn`.
- rs1 is used for opcodes 51, 19, 3, 35, 103 and 99.
- rs2 is used for opcodes 51, 35 and 99.

Load-use detection is combinational:
- `load_use` = `state==RUN` & `valid_id` & `id_ex_mem_read` & (`id_ex_rd`≠0) & ((rs1 used & `id_ex_rd`==`instr_id[19:15]`) | (rs2 used & `id_ex_rd`==`instr_id[24:20]`)).

Combinational outputs:
- `MuxControlEn` = `load_use` | `branch_taken` | ~`valid_id`.
- `pc_write` = ~`stall_ext` & (`branch_taken` | ~`load_use`).

FSM states are RUN and STALL:
- RUN→STALL when `load_use` & ~`branch_taken` & ~`stall_ext`.
- STALL→RUN on the next non-frozen edge, unconditionally. The EX stage then holds the inserted bubble, so no re-detection is needed.
- A `branch_taken` edge always ends in RUN.

Register update on each rising edge, highest priority first:
1. `rst_n`=0: `pc_id`=0, `instr_id`=`NOP_INSTR`, `valid_id`=0, state=RUN, both counters=0.
2. `stall_ext`=1: all state holds. Counters do not increment.
3. `branch_taken`: `instr_id`=`NOP_INSTR`, `valid_id`=0, `pc_id`=`pc_if`, and `flush_cnt` increments. Flush wins over load-use.
4. `load_use`: `pc_id`, `instr_id` and `valid_id` hold, and `stall_cnt` increments.
5. Otherwise: `pc_id`=`pc_if`, `instr_id`=(`fetch_valid` ? `instr_if` : `NOP_INSTR`), `valid_id`=`fetch_valid`.

Counters saturate at all-ones and never wrap.

## Timing
- Decode sees a fetched instruction one cycle after it is presented with `fetch_valid`=1.
- A load-use hazard costs exactly one bubble:
  - cycle N: `MuxControlEn`=1, `pc_write`=0;
  - cycle N+1: same `instr_id` with `MuxControlEn`=0.
- A taken branch asserted in cycle N:
  - cycle N: the current ID instruction is nulled via `MuxControlEn`=1;
  - cycle N+1: `instr_id`=NOP and `valid_id`=0.
  - This gives two squashed slots total.
- Simultaneous `branch_taken` and `load_use`: the flush is taken, `pc_write`=1, and `stall_cnt` is unchanged.
- `stall_ext` while in STALL: the FSM stays in STALL until the first non-frozen edge.
- Reset asserted mid-stall: the next edge returns to the reset values, and state is RUN.
- After reset: `MuxControlEn`=1 and `pc_write`=1 until the first valid fetch is registered.

## Test plan
- Reset, then fetch `addi x1,x0,5` at PC 0x0 with `fetch_valid`=1 → next cycle `instr_id`=0x00500093, `pc_id`=0, `valid_id`=1, `MuxControlEn`=0.
- `id_ex_mem_read`=1, `id_ex_rd`=5, `instr_id`=`add x3,x5,x6` → one cycle with `MuxControlEn`=1 and `pc_write`=0, then the same `instr_id` proceeds; `stall_cnt`=1.
- Same as above but `instr_id`=`lui x5,1` (no rs used), or `id_ex_rd`=0 → no stall; `stall_cnt` stays 0.
- `branch_taken`=1 concurrent with a load-use hazard → `pc_write`=1; next cycle `instr_id`=0x00000013, `valid_id`=0, `flush_cnt`=1, `stall_cnt`=0.
- `fetch_valid`=0 for 3 cycles → `valid_id`=0 and `MuxControlEn`=1 for 3 cycles. Then `stall_ext`=1 for 2 cycles during a stall → outputs frozen, `stall_cnt` increments only once.
- Force 2^`CNT_W`+3 flushes → `flush_cnt` holds at 0xFFFF.

Source files
------------

// File: rtl/if_id_stage_if.sv
// Fetch-to-decode bus for the IF/ID pipeline register: fetch/hazard inputs
// plus the registered decode-side outputs and performance counters.
interface if_id_stage_if #(
    parameter int unsigned CNT_W = 16
);
    logic [31:0]      pc_if;
    logic [31:0]      instr_if;
    logic             fetch_valid;
    logic             stall_ext;
    logic             branch_taken;
    logic             id_ex_mem_read;
    logic [4:0]       id_ex_rd;
    logic [31:0]      pc_id;
    logic [31:0]      instr_id;
    logic             valid_id;
    logic             MuxControlEn;
    logic             pc_write;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output pc_if, instr_if, fetch_valid, stall_ext, branch_taken,
               id_ex_mem_read, id_ex_rd,
        input  pc_id, instr_id, valid_id, MuxControlEn, pc_write,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  pc_if, instr_if, fetch_valid, stall_ext, branch_taken,
               id_ex_mem_read, id_ex_rd,
        output pc_id, instr_id, valid_id, MuxControlEn, pc_write,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use hazard detection, branch flush and
// saturating stall/flush performance counters.
module if_id_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int unsigned CNT_W     = 16
) (
    input logic          clk,
    input logic          rst_n,
    if_id_stage_if.slave bus
);
    localparam logic [6:0] OP_REG    = 7'd51;
    localparam logic [6:0] OP_IMM    = 7'd19;
    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [6:0] OP_JALR   = 7'd103;
    localparam logic [6:0] OP_BRANCH = 7'd99;

    typedef enum logic {RUN, STALL} state_t;

    state_t           stateQ, stateD;
    logic [31:0]      pcIdQ, pcIdD;
    logic [31:0]      instrIdQ, instrIdD;
    logic             validIdQ, validIdD;
    logic [CNT_W-1:0] stallCntQ, stallCntD;
    logic [CNT_W-1:0] flushCntQ, flushCntD;

    logic [6:0]       opcode;
    logic             rs1Used;
    logic             rs2Used;
    logic             loadUse;

    // Local source-register decode keeps MuxControlEn free of a loop through the decoder
    always_comb begin
        opcode  = instrIdQ[6:0];
        rs1Used = opcode inside {OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_JALR, OP_BRANCH};
        rs2Used = opcode inside {OP_REG, OP_STORE, OP_BRANCH};
        loadUse = (stateQ == RUN) && validIdQ && bus.id_ex_mem_read
               && (bus.id_ex_rd != 5'd0)
               && ((rs1Used && (bus.id_ex_rd == instrIdQ[19:15]))
                || (rs2Used && (bus.id_ex_rd == instrIdQ[24:20])));
    end

    // Next-state: freeze > flush > load-use hold > normal advance
    always_comb begin
        stateD    = stateQ;
        pcIdD     = pcIdQ;
        instrIdD  = instrIdQ;
        validIdD  = validIdQ;
        stallCntD = stallCntQ;
        flushCntD = flushCntQ;

        if (!bus.stall_ext) begin
            if (bus.branch_taken) begin
                stateD    = RUN;
                pcIdD     = bus.pc_if;
                instrIdD  = NOP_INSTR;
                validIdD  = 1'b0;
                flushCntD = (flushCntQ == '1) ? flushCntQ : flushCntQ + CNT_W'(1);
            end else if (loadUse) begin
                stateD    = STALL;
                stallCntD = (stallCntQ == '1) ? stallCntQ : stallCntQ + CNT_W'(1);
            end else begin
                // Bubble already sits in EX after a stall, so STALL always returns to RUN
                stateD   = RUN;
                pcIdD    = bus.pc_if;
                instrIdD = bus.fetch_valid ? bus.instr_if : NOP_INSTR;
                validIdD = bus.fetch_valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateQ    <= RUN;
            pcIdQ     <= 32'd0;
            instrIdQ  <= NOP_INSTR;
            validIdQ  <= 1'b0;
            stallCntQ <= '0;
            flushCntQ <= '0;
        end else begin
            stateQ    <= stateD;
            pcIdQ     <= pcIdD;
            instrIdQ  <= instrIdD;
            validIdQ  <= validIdD;
            stallCntQ <= stallCntD;
            flushCntQ <= flushCntD;
        end
    end

    assign bus.pc_id        = pcIdQ;
    assign bus.instr_id     = instrIdQ;
    assign bus.valid_id     = validIdQ;
    assign bus.stall_cnt    = stallCntQ;
    assign bus.flush_cnt    = flushCntQ;
    assign bus.MuxControlEn = loadUse | bus.branch_taken | ~validIdQ;
    assign bus.pc_write     = ~bus.stall_ext & (bus.branch_taken | ~loadUse);

endmodule
